// File: rtl/buffer_pkg.sv
// Shared types and sizing for the packet buffer access arbiter.
// Optional error flag logic is enabled by defining BUF_ERR_EN.
package buffer_pkg;
  localparam int BUF_DEPTH = 64;
  localparam int BUF_PTR_W = $clog2(BUF_DEPTH);
  localparam int BUF_OCC_W = BUF_PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TX   = 2'd2
  } mode_t;
endpackage

// File: rtl/buf_ptr_counter.sv
// Power-of-two wrap counter used for the buffer write and read addresses.
module buf_ptr_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  // Natural overflow of the W-bit register gives the mod-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (inc_i)   cnt_q <= cnt_q + W'(1);
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/buffer_access_arbiter.sv
// Arbitrates the shared packet buffer between the RX (USB store / AHB get) and
// TX (AHB store / USB get) paths. Define BUF_ERR_EN to build sticky err_flags.
module buffer_access_arbiter
  import buffer_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int OCC_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             rx_store_req,
  input  logic             tx_store_req,
  input  logic             rx_get_req,
  input  logic             tx_get_req,
  input  logic             rx_busy,
  input  logic             tx_busy,
  output logic             rx_store_gnt,
  output logic             tx_store_gnt,
  output logic             rx_get_gnt,
  output logic             tx_get_gnt,
  output logic             store_en,
  output logic             get_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic [1:0]       mode,
  output logic [2:0]       err_flags
);
  // Handshake: each *_req is a level held by the requester until the matching
  // *_gnt is seen high in the same cycle; a high gnt means the transfer happens
  // this cycle and the pointer/occupancy move on the following edge.

  mode_t            mode_q, mode_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             flush;
  logic             full, empty;
  logic             st, gt;

  assign flush = rst | clear;
  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);

  always_comb begin
    rx_store_gnt = 1'b0;
    tx_store_gnt = 1'b0;
    rx_get_gnt   = 1'b0;
    tx_get_gnt   = 1'b0;
    mode_d       = mode_q;
    occ_d        = occ_q;
    st           = 1'b0;
    gt           = 1'b0;
    if (!flush) begin
      case (mode_q)
        IDLE: begin
          // Buffer is empty in IDLE, so the winning store needs no room check.
          if (rx_store_req) begin
            rx_store_gnt = 1'b1;
            mode_d       = RX;
          end else if (tx_store_req) begin
            tx_store_gnt = 1'b1;
            mode_d       = TX;
          end
        end
        RX: begin
          rx_store_gnt = rx_store_req & ~full;
          rx_get_gnt   = rx_get_req & ~empty;
        end
        TX: begin
          tx_store_gnt = tx_store_req & ~full;
          tx_get_gnt   = tx_get_req & ~empty;
        end
        default: mode_d = IDLE;
      endcase
      st = rx_store_gnt | tx_store_gnt;
      gt = rx_get_gnt | tx_get_gnt;
      if (st && !gt)      occ_d = occ_q + OCC_W'(1);
      else if (gt && !st) occ_d = occ_q - OCC_W'(1);
      if (mode_q == RX && occ_d == '0 && !rx_busy) mode_d = IDLE;
      if (mode_q == TX && occ_d == '0 && !tx_busy) mode_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      mode_q <= IDLE;
      occ_q  <= '0;
    end else begin
      mode_q <= mode_d;
      occ_q  <= occ_d;
    end
  end

  assign store_en         = rx_store_gnt | tx_store_gnt;
  assign get_en           = rx_get_gnt | tx_get_gnt;
  assign buffer_occupancy = occ_q;
  assign mode             = mode_q;

  buf_ptr_counter #(.W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clear),
    .inc_i (store_en),
    .cnt_o (wr_ptr)
  );

  buf_ptr_counter #(.W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clear),
    .inc_i (get_en),
    .cnt_o (rd_ptr)
  );

`ifdef BUF_ERR_EN
  logic [2:0] err_q, err_d;

  // Bit order {conflict, underflow, overflow}; flags only fire with an owner.
  always_comb begin
    err_d = err_q;
    case (mode_q)
      RX: begin
        if (rx_store_req && full)  err_d[0] = 1'b1;
        if (rx_get_req && empty)   err_d[1] = 1'b1;
        if (tx_store_req)          err_d[2] = 1'b1;
      end
      TX: begin
        if (tx_store_req && full)  err_d[0] = 1'b1;
        if (tx_get_req && empty)   err_d[1] = 1'b1;
        if (rx_store_req)          err_d[2] = 1'b1;
      end
      default: err_d = err_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) err_q <= '0;
    else       err_q <= err_d;
  end

  assign err_flags = err_q;
`else
  assign err_flags = 3'b000;
`endif
endmodule

// File: tb/tb_buffer_access_arbiter.sv
// Self-checking bench for buffer_access_arbiter: directed vector table, corner
// sequences (full, drain, simultaneous, mid-operation clear) and random traffic.
module tb_buffer_access_arbiter;
`ifdef BUF_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst, clear;
  logic       rx_store_req, tx_store_req, rx_get_req, tx_get_req;
  logic       rx_busy, tx_busy;
  logic       rx_store_gnt, tx_store_gnt, rx_get_gnt, tx_get_gnt;
  logic       store_en, get_en;
  logic [5:0] wr_ptr, rd_ptr;
  logic [6:0] buffer_occupancy;
  logic [1:0] mode;
  logic [2:0] err_flags;

  buffer_access_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .clear            (clear),
    .rx_store_req     (rx_store_req),
    .tx_store_req     (tx_store_req),
    .rx_get_req       (rx_get_req),
    .tx_get_req       (tx_get_req),
    .rx_busy          (rx_busy),
    .tx_busy          (tx_busy),
    .rx_store_gnt     (rx_store_gnt),
    .tx_store_gnt     (tx_store_gnt),
    .rx_get_gnt       (rx_get_gnt),
    .tx_get_gnt       (tx_get_gnt),
    .store_en         (store_en),
    .get_en           (get_en),
    .wr_ptr           (wr_ptr),
    .rd_ptr           (rd_ptr),
    .buffer_occupancy (buffer_occupancy),
    .mode             (mode),
    .err_flags        (err_flags)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  // Tracks total granted stores/gets since the last flush; pointers are those
  // totals mod 64 and occupancy is their difference.
  localparam int M_IDLE = 0, M_RX = 1, M_TX = 2;
  int       m_mode, m_st, m_gt;
  bit [2:0] m_err;
  logic [3:0] e_gnt;
  logic [29:0] obs_vec, exp_vec;

  function automatic logic [29:0] pack_obs();
    return {rx_store_gnt, tx_store_gnt, rx_get_gnt, tx_get_gnt, store_en, get_en,
            wr_ptr, rd_ptr, buffer_occupancy, mode, err_flags};
  endfunction

  function automatic logic [29:0] pack_exp(logic [3:0] g, logic [5:0] w, logic [5:0] r,
                                           logic [6:0] o, logic [1:0] md, logic [2:0] er);
    return {g, |g[3:2], |g[1:0], w, r, o, md, ERR_EN ? er : 3'b000};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs {rst,clr,rxs,txs,rxg,txg,rxb,txb}, compare all
  // outputs against the model, then advance the model across the coming edge.
  task automatic apply(input logic [7:0] v);
    int occ, n_mode, n_st, n_gt;
    bit own_s, own_g, oth_s, own_b, gs, gg;
    bit [2:0] n_err;
    @(negedge clk);
    {rst, clear, rx_store_req, tx_store_req, rx_get_req, tx_get_req, rx_busy, tx_busy} = v;
    #1;
    occ = m_st - m_gt;
    e_gnt = 4'b0000;
    n_mode = m_mode; n_st = m_st; n_gt = m_gt; n_err = m_err;
    if (v[7] || v[6]) begin
      n_mode = M_IDLE; n_st = 0; n_gt = 0; n_err = 3'b000;
    end else if (m_mode == M_IDLE) begin
      if (v[5])      begin e_gnt[3] = 1'b1; n_mode = M_RX; n_st = m_st + 1; end
      else if (v[4]) begin e_gnt[2] = 1'b1; n_mode = M_TX; n_st = m_st + 1; end
    end else begin
      own_s = (m_mode == M_RX) ? v[5] : v[4];
      oth_s = (m_mode == M_RX) ? v[4] : v[5];
      own_g = (m_mode == M_RX) ? v[3] : v[2];
      own_b = (m_mode == M_RX) ? v[1] : v[0];
      gs = own_s && occ < 64;
      gg = own_g && occ > 0;
      if (m_mode == M_RX) begin e_gnt[3] = gs; e_gnt[1] = gg; end
      else                begin e_gnt[2] = gs; e_gnt[0] = gg; end
      if (own_s && occ == 64) n_err[0] = 1'b1;
      if (own_g && occ == 0)  n_err[1] = 1'b1;
      if (oth_s)              n_err[2] = 1'b1;
      n_st = m_st + int'(gs);
      n_gt = m_gt + int'(gg);
      if (n_st - n_gt == 0 && !own_b) n_mode = M_IDLE;
    end
    obs_vec = pack_obs();
    exp_vec = pack_exp(e_gnt, 6'(m_st % 64), 6'(m_gt % 64), 7'(occ), 2'(m_mode), m_err);
    check("model", {2'b00, obs_vec}, {2'b00, exp_vec});
    m_mode = n_mode; m_st = n_st; m_gt = n_gt; m_err = n_err;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string      name;
    logic [7:0] in;
    logic [3:0] gnt;
    logic [6:0] occ;
    logic [5:0] wr;
    logic [5:0] rd;
    logic [1:0] md;
    logic [2:0] err;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // in = {rst,clr,rxs,txs,rxg,txg,rxb,txb}; gnt = {rxs,txs,rxg,txg}
    tbl[0]  = '{"rst_hold",      8'b1011_0000, 4'b0000, 7'd0, 6'd0, 6'd0, 2'd0, 3'b000};
    tbl[1]  = '{"idle_quiet",    8'b0000_0000, 4'b0000, 7'd0, 6'd0, 6'd0, 2'd0, 3'b000};
    tbl[2]  = '{"idle_rx_wins",  8'b0011_0010, 4'b1000, 7'd0, 6'd0, 6'd0, 2'd0, 3'b000};
    tbl[3]  = '{"rx_store2",     8'b0010_0010, 4'b1000, 7'd1, 6'd1, 6'd0, 2'd1, 3'b000};
    tbl[4]  = '{"rx_store3",     8'b0010_0010, 4'b1000, 7'd2, 6'd2, 6'd0, 2'd1, 3'b000};
    tbl[5]  = '{"rx_conflict",   8'b0001_0010, 4'b0000, 7'd3, 6'd3, 6'd0, 2'd1, 3'b000};
    tbl[6]  = '{"rx_tx_get",     8'b0000_0110, 4'b0000, 7'd3, 6'd3, 6'd0, 2'd1, 3'b100};
    tbl[7]  = '{"rx_both",       8'b0010_1010, 4'b1010, 7'd3, 6'd3, 6'd0, 2'd1, 3'b100};
    tbl[8]  = '{"rx_get",        8'b0000_1010, 4'b0010, 7'd3, 6'd4, 6'd1, 2'd1, 3'b100};
    tbl[9]  = '{"rx_get_idle_b", 8'b0000_1000, 4'b0010, 7'd2, 6'd4, 6'd2, 2'd1, 3'b100};
    tbl[10] = '{"rx_last_get",   8'b0000_1000, 4'b0010, 7'd1, 6'd4, 6'd3, 2'd1, 3'b100};
    tbl[11] = '{"idle_get_deny", 8'b0000_1000, 4'b0000, 7'd0, 6'd4, 6'd4, 2'd0, 3'b100};
    tbl[12] = '{"idle_tx",       8'b0001_0001, 4'b0100, 7'd0, 6'd4, 6'd4, 2'd0, 3'b100};
    tbl[13] = '{"tx_entered",    8'b0000_0001, 4'b0000, 7'd1, 6'd5, 6'd4, 2'd2, 3'b100};
  end

  // ---------------- test sequence ----------------
  initial begin
    {rst, clear, rx_store_req, tx_store_req, rx_get_req, tx_get_req, rx_busy, tx_busy} = 8'h80;
    m_mode = M_IDLE; m_st = 0; m_gt = 0; m_err = 3'b000;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].in);
      check(tbl[i].name, {2'b00, obs_vec},
            {2'b00, pack_exp(tbl[i].gnt, tbl[i].wr, tbl[i].rd, tbl[i].occ, tbl[i].md, tbl[i].err)});
    end

    // Fill to 64 in TX, then a refused 65th store.
    apply(8'b0100_0000);
    for (int i = 0; i < 64; i++) apply(8'b0001_0001);
    after_edge();
    check("full_occ", 32'(buffer_occupancy), 32'd64);
    check("full_wr_wrap", 32'(wr_ptr), 32'd0);
    check("full_mode", 32'(mode), 32'd2);
    apply(8'b0001_0001);
    check("overflow_gnt", 32'(tx_store_gnt), 32'd0);
    after_edge();
    check("overflow_flag", 32'(err_flags), ERR_EN ? 32'd1 : 32'd0);

    // Drain with tx_busy held: mode stays TX at empty, then empty get refused.
    for (int i = 0; i < 64; i++) apply(8'b0000_0101);
    after_edge();
    check("drain_busy_occ", 32'(buffer_occupancy), 32'd0);
    check("drain_busy_mode", 32'(mode), 32'd2);
    apply(8'b0000_0101);
    check("underflow_gnt", 32'(tx_get_gnt), 32'd0);
    after_edge();
    check("underflow_flag", 32'(err_flags), ERR_EN ? 32'd3 : 32'd0);
    apply(8'b0001_0001);
    apply(8'b0000_0100);
    after_edge();
    check("drain_idle_occ", 32'(buffer_occupancy), 32'd0);
    check("drain_idle_mode", 32'(mode), 32'd0);

    // Simultaneous store and get at occupancy 10 in RX.
    apply(8'b0100_0000);
    for (int i = 0; i < 10; i++) apply(8'b0010_0010);
    apply(8'b0010_1010);
    after_edge();
    check("simul_occ", 32'(buffer_occupancy), 32'd10);
    check("simul_ptrs", {20'd0, wr_ptr, rd_ptr}, {20'd0, 6'd11, 6'd1});

    // Clear at occupancy 37 with a store pending.
    apply(8'b0100_0000);
    for (int i = 0; i < 37; i++) apply(8'b0001_0001);
    after_edge();
    check("pre_clear_occ", 32'(buffer_occupancy), 32'd37);
    apply(8'b0101_0001);
    check("clear_no_gnt", {28'd0, rx_store_gnt, tx_store_gnt, store_en, get_en}, 32'd0);
    after_edge();
    check("clear_state", {8'd0, wr_ptr, rd_ptr, buffer_occupancy, mode, err_flags},
          32'd0);

    // Random traffic, alternating fill-biased and drain-biased windows.
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] v;
      int sp, gp;
      sp = ((i / 400) % 2 == 0) ? 90 : 35;
      gp = ((i / 400) % 2 == 0) ? 20 : 70;
      v[7] = ($urandom_range(0, 999) == 0);
      v[6] = ($urandom_range(0, 299) == 0);
      v[5] = ($urandom_range(0, 99) < sp);
      v[4] = ($urandom_range(0, 99) < sp);
      v[3] = ($urandom_range(0, 99) < gp);
      v[2] = ($urandom_range(0, 99) < gp);
      v[1] = ($urandom_range(0, 99) < 60);
      v[0] = ($urandom_range(0, 99) < 60);
      apply(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
